// File: rtl/clk_gen_pkg.sv
// Shared types and helpers for the phase-aligned clock divider.
// Config fields are held at MAX_CNT_W bits; instances must use CNT_W <= MAX_CNT_W.
package clk_gen_pkg;

   localparam int MAX_CNT_W = 16;
   localparam int MIN_DIV   = 2;

   typedef struct packed {
      logic [MAX_CNT_W-1:0] div;
      logic [MAX_CNT_W-1:0] phase;
      logic                 inv;
      logic                 en;
   } chan_cfg_t;

   // Clamp the divide ratio first, then validate the phase against the clamped ratio
   function automatic chan_cfg_t sanitize_cfg(input logic [MAX_CNT_W-1:0] div,
                                              input logic [MAX_CNT_W-1:0] phase,
                                              input logic                 inv,
                                              input logic                 en);
      chan_cfg_t c;
      c.div   = (div < MAX_CNT_W'(MIN_DIV)) ? MAX_CNT_W'(MIN_DIV) : div;
      c.phase = (phase >= c.div) ? '0 : phase;
      c.inv   = inv;
      c.en    = en;
      return c;
   endfunction

endpackage

// File: rtl/clk_phase_chan.sv
// One derived-clock channel: active/shadow config, wrap counter and registered output.
module clk_phase_chan
   import clk_gen_pkg::*;
#(
   parameter int CNT_W     = 8,
   parameter int RESET_DIV = 2
) (
   input  logic      clock,
   input  logic      reset,
   input  logic      align,
   input  logic      cfg_load,
   input  chan_cfg_t cfg_in,
   output logic      clk_out,
   output logic      wrap,
   output logic      pending
);

   localparam chan_cfg_t RST_CFG = '{div: MAX_CNT_W'(RESET_DIV), phase: '0, inv: 1'b0, en: 1'b1};

   chan_cfg_t            act_q, act_d;
   chan_cfg_t            shd_q, shd_d;
   chan_cfg_t            nxt;
   logic                 pend_q, pend_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 clk_out_q, clk_out_d;
   logic                 wrap_q, wrap_d;
   logic [MAX_CNT_W-1:0] cnt_x, cnt_nx;
   logic                 last, apply;

   always_comb begin
      cnt_x  = MAX_CNT_W'(cnt_q);
      last   = (cnt_x == act_q.div - MAX_CNT_W'(1));
      // Enabled channels swap config only at the end of a period; idle ones swap at once
      apply  = pend_q && (!act_q.en || last);
      nxt    = apply ? shd_q : act_q;
      act_d  = nxt;
      shd_d  = cfg_load ? cfg_in : shd_q;
      pend_d = cfg_load || (pend_q && !apply);

      if (!nxt.en) begin
         cnt_nx = nxt.div - MAX_CNT_W'(1);
      end else if (align) begin
         cnt_nx = nxt.phase;
      end else if (!act_q.en || last) begin
         cnt_nx = '0;
      end else begin
         cnt_nx = cnt_x + MAX_CNT_W'(1);
      end
      cnt_d = CNT_W'(cnt_nx);

      clk_out_d = nxt.en ? ((cnt_nx < (nxt.div >> 1)) ^ nxt.inv) : nxt.inv;
      wrap_d    = nxt.en && (cnt_nx == '0);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         act_q     <= RST_CFG;
         shd_q     <= '0;
         pend_q    <= 1'b0;
         cnt_q     <= CNT_W'(RESET_DIV - 1);
         clk_out_q <= 1'b0;
         wrap_q    <= 1'b0;
      end else begin
         act_q     <= act_d;
         shd_q     <= shd_d;
         pend_q    <= pend_d;
         cnt_q     <= cnt_d;
         clk_out_q <= clk_out_d;
         wrap_q    <= wrap_d;
      end
   end

   assign clk_out = clk_out_q;
   assign wrap    = wrap_q;
   assign pending = pend_q;

endmodule

// File: rtl/clk_phase_gen.sv
// Multi-channel programmable clock divider with shadowed config and global realign.
// Top level decodes the config handshake and fans it out to the channels.
module clk_phase_gen
   import clk_gen_pkg::*;
#(
   parameter int NUM_CH    = 4,
   parameter int CNT_W     = 8,
   parameter int RESET_DIV = 2,
   localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [CNT_W-1:0]  cfg_div,
   input  logic [CNT_W-1:0]  cfg_phase,
   input  logic              cfg_inv,
   input  logic              cfg_en,
   input  logic              align,
   output logic [NUM_CH-1:0] clk_out,
   output logic [NUM_CH-1:0] wrap,
   output logic [NUM_CH-1:0] pending
);

   chan_cfg_t         cfg_sane;
   logic [NUM_CH-1:0] cfg_load;

   assign cfg_sane = sanitize_cfg(MAX_CNT_W'(cfg_div), MAX_CNT_W'(cfg_phase), cfg_inv, cfg_en);

   // Channel numbers with no matching channel stay ready, so such writes are simply dropped
   always_comb begin
      cfg_ready = 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
         if (cfg_ch == CH_W'(i)) cfg_ready = !pending[i];
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      assign cfg_load[g] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(g));

      clk_phase_chan #(
         .CNT_W     (CNT_W),
         .RESET_DIV (RESET_DIV)
      ) u_chan (
         .clock    (clock),
         .reset    (reset),
         .align    (align),
         .cfg_load (cfg_load[g]),
         .cfg_in   (cfg_sane),
         .clk_out  (clk_out[g]),
         .wrap     (wrap[g]),
         .pending  (pending[g])
      );
   end

endmodule

// File: tb/tb_clk_phase_gen.sv
// Directed bench for clk_phase_gen with hand-computed expected waveforms.
module tb_clk_phase_gen;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       cfg_valid = 1'b0;
   logic       cfg_ready;
   logic [1:0] cfg_ch = '0;
   logic [7:0] cfg_div = '0;
   logic [7:0] cfg_phase = '0;
   logic       cfg_inv = 1'b0;
   logic       cfg_en = 1'b0;
   logic       align = 1'b0;
   logic [3:0] clk_out, wrap, pending;

   int checks = 0;
   int errors = 0;

   logic [3:0] s1_clk  [6] = '{4'hF, 4'h2, 4'hD, 4'h0, 4'hD, 4'h2};
   logic [3:0] s1_wrap [6] = '{4'hF, 4'h0, 4'hD, 4'h0, 4'hD, 4'h2};
   logic [1:0] s3_clk  [8] = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01, 2'b10, 2'b10};
   logic [1:0] s3_wrap [8] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
   logic [3:0] s4_clk  [5] = '{4'h8, 4'hF, 4'h0, 4'h7, 4'h8};
   logic [3:0] s4_wrap [5] = '{4'h8, 4'h7, 4'h0, 4'h7, 4'h8};

   clk_phase_gen #(.NUM_CH(4), .CNT_W(8), .RESET_DIV(2)) dut (
      .clock     (clock),
      .reset     (reset),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_ch    (cfg_ch),
      .cfg_div   (cfg_div),
      .cfg_phase (cfg_phase),
      .cfg_inv   (cfg_inv),
      .cfg_en    (cfg_en),
      .align     (align),
      .clk_out   (clk_out),
      .wrap      (wrap),
      .pending   (pending)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive_cfg(input logic [1:0] ch, input logic [7:0] div, input logic [7:0] ph,
                            input logic inv, input logic en);
      cfg_valid = 1'b1;
      cfg_ch    = ch;
      cfg_div   = div;
      cfg_phase = ph;
      cfg_inv   = inv;
      cfg_en    = en;
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      cfg_valid = 1'b0;
      align     = 1'b0;
      tick();
      tick();
   endtask

   initial begin
      // Reset defaults, then a D=5 reconfig of ch1 during the D=2 run
      do_reset();
      chk("rst_clk", clk_out, 4'h0);
      chk("rst_wrap", wrap, 4'h0);
      chk("rst_pend", pending, 4'h0);
      chk("rst_ready", cfg_ready, 1'b1);
      reset = 1'b0;
      tick();
      chk("rel_clk0", clk_out, 4'hF);
      chk("rel_wrap0", wrap, 4'hF);
      tick();
      chk("rel_clk1", clk_out, 4'h0);
      chk("rel_wrap1", wrap, 4'h0);
      tick();
      chk("rel_clk2", clk_out, 4'hF);
      drive_cfg(2'd1, 8'd5, 8'd0, 1'b0, 1'b1);
      #1;
      chk("d5_ready_pre", cfg_ready, 1'b1);
      tick();
      cfg_valid = 1'b0;
      chk("d5_pend", pending, 4'h2);
      chk("d5_clk_wait", clk_out, 4'h0);
      #1;
      chk("d5_ready_busy", cfg_ready, 1'b0);
      for (int i = 0; i < 6; i++) begin
         tick();
         chk($sformatf("d5_clk%0d", i), clk_out, s1_clk[i]);
         chk($sformatf("d5_wrap%0d", i), wrap, s1_wrap[i]);
      end
      chk("d5_pend_clr", pending, 4'h0);

      // Clamping of D=1 / phase=9 on ch2, observed via align
      do_reset();
      reset = 1'b0;
      tick();
      drive_cfg(2'd2, 8'd1, 8'd9, 1'b0, 1'b1);
      tick();
      cfg_valid = 1'b0;
      chk("clamp_pend", pending, 4'h4);
      tick();
      chk("clamp_pend_clr", pending, 4'h0);
      chk("clamp_clk_a", clk_out, 4'hF);
      tick();
      chk("clamp_clk_b", clk_out, 4'h0);
      tick();
      chk("clamp_clk_c", clk_out, 4'hF);
      align = 1'b1;
      tick();
      align = 1'b0;
      chk("clamp_align_clk", clk_out, 4'hF);
      chk("clamp_align_wrap", wrap, 4'hF);
      tick();
      chk("clamp_clk_d", clk_out, 4'h0);

      // 180-degree pair: ch0 D=4 phase 0, ch1 D=4 phase 2, then align
      do_reset();
      reset = 1'b0;
      tick();
      drive_cfg(2'd0, 8'd4, 8'd0, 1'b0, 1'b1);
      tick();
      chk("ph_pend0", pending, 4'h1);
      drive_cfg(2'd1, 8'd4, 8'd2, 1'b0, 1'b1);
      #1;
      chk("ph_ready_ch1", cfg_ready, 1'b1);
      tick();
      cfg_valid = 1'b0;
      chk("ph_pend1", pending, 4'h2);
      tick();
      tick();
      chk("ph_pend_clr", pending, 4'h0);
      align = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         align = 1'b0;
         chk($sformatf("ph_clk%0d", i), clk_out[1:0], s3_clk[i]);
         chk($sformatf("ph_wrap%0d", i), wrap[1:0], s3_wrap[i]);
      end

      // ch3 disabled with inversion, then re-enabled at D=4
      do_reset();
      reset = 1'b0;
      tick();
      drive_cfg(2'd3, 8'd2, 8'd0, 1'b1, 1'b0);
      tick();
      cfg_valid = 1'b0;
      chk("dis_pend", pending, 4'h8);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk($sformatf("dis_clk%0d", i), clk_out, (i % 2 == 0) ? 4'hF : 4'h8);
         chk($sformatf("dis_wrap%0d", i), wrap, (i % 2 == 0) ? 4'h7 : 4'h0);
      end
      chk("dis_pend_clr", pending, 4'h0);
      drive_cfg(2'd3, 8'd4, 8'd0, 1'b0, 1'b1);
      tick();
      cfg_valid = 1'b0;
      chk("en_pend", pending, 4'h8);
      chk("en_clk_idle", clk_out, 4'hF);
      chk("en_wrap_idle", wrap, 4'h7);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("en_clk%0d", i), clk_out, s4_clk[i]);
         chk($sformatf("en_wrap%0d", i), wrap, s4_wrap[i]);
      end

      // Reset while ch0 has a pending config
      do_reset();
      reset = 1'b0;
      tick();
      drive_cfg(2'd0, 8'd6, 8'd0, 1'b0, 1'b1);
      tick();
      cfg_valid = 1'b0;
      chk("rp_pend", pending, 4'h1);
      reset = 1'b1;
      tick();
      chk("rp_pend_clr", pending, 4'h0);
      chk("rp_clk_rst", clk_out, 4'h0);
      reset = 1'b0;
      tick();
      chk("rp_clk0", clk_out, 4'hF);
      chk("rp_wrap0", wrap, 4'hF);
      tick();
      chk("rp_clk1", clk_out, 4'h0);
      tick();
      chk("rp_clk2", clk_out, 4'hF);
      chk("rp_pend_end", pending, 4'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
